// File: rtl/encoder_pkg.sv
// Shared constants for the sequential priority encoder: FSM state encoding
// and default request/code widths.
package encoder_pkg;

    localparam int N_IN_DEF  = 16;
    localparam int W_OUT_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_STALL = 2'd2
    } state_t;

endpackage

// File: rtl/pe_16to4.sv
// Combinational priority encoder: picks the highest or lowest set bit of the
// vector and returns its index plus a one-hot mask of that bit.
module pe_16to4 #(
    parameter int N_IN  = 16,
    parameter int W_OUT = 4
) (
    input  logic [N_IN-1:0]  vector,
    input  logic             high_first,
    output logic [W_OUT-1:0] index,
    output logic             found,
    output logic [N_IN-1:0]  grant_mask
);

    always_comb begin
        index = '0;
        found = |vector;
        // The last match in scan order wins, so scan away from the preferred end.
        if (high_first) begin
            for (int i = 0; i < N_IN; i++) begin
                if (vector[i]) index = W_OUT'(i);
            end
        end else begin
            for (int i = N_IN - 1; i >= 0; i--) begin
                if (vector[i]) index = W_OUT'(i);
            end
        end
        grant_mask = found ? (N_IN'(1) << index) : '0;
    end

endmodule

// File: rtl/encoder_16to4_seq.sv
// Sequential 16-to-4 priority encoder: OR-merges requests into a pending
// register and drains them one code per accepted valid/ready transfer.
//
//   state    | meaning
//   ST_IDLE  | nothing pending, no code on the output
//   ST_SERVE | a code is loading or being accepted this cycle
//   ST_STALL | code presented but the sink held off (out_ready=0)
module encoder_16to4_seq
    import encoder_pkg::*;
#(
    parameter int N_IN       = N_IN_DEF,
    parameter int W_OUT      = W_OUT_DEF,
    parameter int HIGH_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             in_valid,
    input  logic [N_IN-1:0]  binary_in,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [W_OUT-1:0] binary_out,
    output logic [N_IN-1:0]  pending_out,
    output logic             busy
);

    state_t           state, state_next;
    logic [N_IN-1:0]  pending, pending_next;
    logic [N_IN-1:0]  grant_mask, clear_mask;
    logic [W_OUT-1:0] pe_index, code_next;
    logic             pe_found, valid_next, slot_free, drained;

    pe_16to4 #(
        .N_IN  (N_IN),
        .W_OUT (W_OUT)
    ) u_pe (
        .vector     (pending),
        .high_first (HIGH_FIRST != 0),
        .index      (pe_index),
        .found      (pe_found),
        .grant_mask (grant_mask)
    );

    // Grant uses the registered pending value; this cycle's merge is not eligible.
    always_comb begin
        slot_free  = !out_valid || out_ready;
        clear_mask = '0;
        valid_next = out_valid;
        code_next  = binary_out;
        if (slot_free) begin
            if (pe_found) begin
                code_next  = pe_index;
                valid_next = 1'b1;
                clear_mask = grant_mask;
            end else begin
                valid_next = 1'b0;
            end
        end
        pending_next = (pending & ~clear_mask) | (in_valid ? binary_in : '0);
        drained      = !valid_next && (pending_next == '0);
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (!drained) state_next = ST_SERVE;
            ST_SERVE: begin
                if (out_valid && !out_ready) state_next = ST_STALL;
                else if (drained)            state_next = ST_IDLE;
            end
            ST_STALL: if (out_ready) state_next = ST_SERVE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            pending    <= '0;
            out_valid  <= 1'b0;
            binary_out <= '0;
        end else if (enable) begin
            state      <= state_next;
            pending    <= pending_next;
            out_valid  <= valid_next;
            binary_out <= code_next;
        end
    end

    assign pending_out = pending;
    assign busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_encoder_16to4_seq.sv
// Bench for encoder_16to4_seq: directed scenarios plus random traffic on a
// high-first and a low-first instance, both checked against a request-set model.
module tb_encoder_16to4_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        in_valid;
    logic [15:0] binary_in;
    logic        out_ready;

    logic        ov_h, ov_l, bz_h, bz_l;
    logic [3:0]  bo_h, bo_l;
    logic [15:0] po_h, po_l;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: pending as a set of request bits, plus the presented code.
    logic [15:0] m_pend  [2];
    logic        m_valid [2];
    logic [3:0]  m_code  [2];
    logic        m_busy  [2];
    logic        m_stall [2];
    int          emit_cnt[2][16];

    always #5 clk = ~clk;

    encoder_16to4_seq #(.N_IN(16), .W_OUT(4), .HIGH_FIRST(1)) u_dut_hi (
        .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid),
        .binary_in(binary_in), .out_ready(out_ready), .out_valid(ov_h),
        .binary_out(bo_h), .pending_out(po_h), .busy(bz_h)
    );

    encoder_16to4_seq #(.N_IN(16), .W_OUT(4), .HIGH_FIRST(0)) u_dut_lo (
        .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid),
        .binary_in(binary_in), .out_ready(out_ready), .out_valid(ov_l),
        .binary_out(bo_l), .pending_out(po_l), .busy(bz_l)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [3:0] pick(input logic [15:0] v, input bit hf);
        if (hf) begin
            for (int i = 15; i >= 0; i--) if (v[i]) return 4'(i);
        end else begin
            for (int i = 0; i < 16; i++) if (v[i]) return 4'(i);
        end
        return 4'd0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pend[k] = '0; m_valid[k] = 1'b0; m_code[k] = '0;
            m_busy[k] = 1'b0; m_stall[k] = 1'b0;
        end
    endtask

    task automatic clear_counts();
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < 16; c++) emit_cnt[k][c] = 0;
    endtask

    task automatic model_step();
        logic [15:0] clr;
        logic        nv;
        for (int k = 0; k < 2; k++) begin
            if (enable) begin
                if (m_valid[k] && out_ready) emit_cnt[k][m_code[k]]++;
                clr = '0;
                nv  = m_valid[k];
                if (!m_valid[k] || out_ready) begin
                    if (m_pend[k] != 0) begin
                        m_code[k] = pick(m_pend[k], k == 0);
                        nv        = 1'b1;
                        clr       = 16'(1) << m_code[k];
                    end else begin
                        nv = 1'b0;
                    end
                end
                m_pend[k] = (m_pend[k] & ~clr) | (in_valid ? binary_in : 16'h0);
                // Busy lingers one cycle after leaving a stall, even if drained.
                m_busy[k]  = nv || (m_pend[k] != 0) || m_stall[k];
                m_stall[k] = m_valid[k] && !out_ready;
                m_valid[k] = nv;
            end
        end
    endtask

    task automatic check_all();
        chk("hi_valid", ov_h, m_valid[0]);
        chk("hi_code",  bo_h, m_code[0]);
        chk("hi_pend",  po_h, m_pend[0]);
        chk("hi_busy",  bz_h, m_busy[0]);
        chk("lo_valid", ov_l, m_valid[1]);
        chk("lo_code",  bo_l, m_code[1]);
        chk("lo_pend",  po_l, m_pend[1]);
        chk("lo_busy",  bz_l, m_busy[1]);
    endtask

    task automatic cyc(input logic en, input logic iv, input logic [15:0] bin, input logic rdy);
        enable = en; in_valid = iv; binary_in = bin; out_ready = rdy;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    // Called at a falling edge; asserts and releases reset before the next rising edge.
    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", {ov_h, ov_l}, 2'b00);
        chk("rst_code",  {bo_h, bo_l}, 8'h00);
        chk("rst_pend",  {po_h, po_l}, 32'h0);
        chk("rst_busy",  {bz_h, bz_l}, 2'b00);
        model_reset();
        #1 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; in_valid = 1'b0; binary_in = '0; out_ready = 1'b0;
        model_reset();
        clear_counts();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_all();

        // Reset in the middle of draining a full vector
        cyc(1, 1, 16'hFFFF, 1);
        repeat (3) cyc(1, 0, 16'h0, 1);
        async_reset();
        enable = 1'b1; in_valid = 1'b0; binary_in = '0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 16'h0, 1);
            chk("post_rst_valid", {ov_h, ov_l}, 2'b00);
        end

        // Single request latency
        cyc(1, 1, 16'h0020, 1);
        chk("single_pend", po_h, 16'h0020);
        chk("single_nv",   ov_h, 1'b0);
        cyc(1, 0, 16'h0, 1);
        chk("single_code", {ov_h, bo_h}, 5'h15);
        cyc(1, 0, 16'h0, 1);
        chk("single_done", {ov_h, bz_h}, 2'b00);

        // Priority drain, both orders
        cyc(1, 1, 16'h8001, 1);
        cyc(1, 0, 16'h0, 1);
        chk("drain1", {bo_h, bo_l}, 8'hF0);
        cyc(1, 0, 16'h0, 1);
        chk("drain2", {bo_h, bo_l}, 8'h0F);
        cyc(1, 0, 16'h0, 1);
        chk("drain_end", {ov_h, ov_l}, 2'b00);

        // Backpressure
        cyc(1, 1, 16'h0C00, 0);
        cyc(1, 0, 16'h0, 0);
        chk("bp_first", {ov_h, bo_h}, 5'h1B);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 16'h0, 0);
            chk("bp_hold_code", bo_h, 4'hB);
            chk("bp_hold_pend", po_h, 16'h0400);
            chk("bp_hold_busy", bz_h, 1'b1);
        end
        cyc(1, 0, 16'h0, 1);
        chk("bp_next", {ov_h, bo_h}, 5'h1A);
        repeat (3) cyc(1, 0, 16'h0, 1);

        // Re-request of the bit being granted
        clear_counts();
        cyc(1, 1, 16'h0008, 1);
        cyc(1, 1, 16'h0008, 1);
        chk("sc_keep", po_h, 16'h0008);
        chk("sc_code", bo_h, 4'h3);
        repeat (3) cyc(1, 0, 16'h0, 1);
        chk("sc_count", emit_cnt[0][3], 2);

        // Enable freeze drops the incoming request
        clear_counts();
        cyc(1, 1, 16'h0080, 1);
        cyc(1, 0, 16'h0, 0);
        cyc(0, 1, 16'h0002, 1);
        chk("frz_code", {ov_h, bo_h}, 5'h17);
        chk("frz_pend", po_h, 16'h0);
        repeat (4) cyc(1, 0, 16'h0, 1);
        chk("frz_drop", emit_cnt[0][1], 0);
        chk("frz_seven", emit_cnt[0][7], 1);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                async_reset();
            end
            cyc($urandom_range(0, 9) != 0,
                $urandom_range(0, 2) == 0,
                16'($urandom_range(0, 65535) & $urandom_range(0, 65535)),
                $urandom_range(0, 3) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
